d16_regfile: RTL and testbench
==============================

D16_REGFILE -- requirements
Module: d16_regfile

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_R0, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 addr_a, addr_b  in  ADDR_W  read port A/B addresses.
REQ-007 qa, qb  out  DATA_W  read port A/B data, combinational.
REQ-008 busy_a, busy_b  out  1  addressed register has a pending long-latency write.
REQ-009 we0, addr_w0, data_w0  in  1/ADDR_W/DATA_W  write port 0 (ALU result).
REQ-010 we1, addr_w1, data_w1  in  1/ADDR_W/DATA_W  write port 1 (load completion).
REQ-011 bs_set, bs_addr  in  1/ADDR_W  mark register pending (load issued).
REQ-012 err  out  1  sticky scoreboard error flag.

Function
REQ-013 Write on rising edge when weN=1; port 1 wins when both ports target the same address.
REQ-014 Read bypass priority per port: ZERO_R0 zero, then we1 match -> data_w1, then we0 match -> data_w0, then stored value.
REQ-015 Read latency zero; write visible on qa/qb same cycle via bypass and from storage the following cycle.
REQ-016 ZERO_R0=1: writes to address 0 discarded; busy bit 0 never set; qa/qb for address 0 always 0.
REQ-017 Scoreboard: one busy bit per register, set on edge by bs_set, cleared on edge by we1 to that address.
REQ-018 bs_set and we1 to the same address in the same cycle: busy ends set (new load supersedes completing one); data_w1 still written.
REQ-019 busy_a = busy[addr_a] AND NOT (we1 AND addr_w1==addr_a); busy_b likewise.
REQ-020 we0 to a busy register: data written, busy bit unchanged.
REQ-021 err set on edge when bs_set targets an already-busy register not cleared by we1 that cycle, or we1 targets a non-busy register; err held until reset.
REQ-022 Addresses wrap naturally within ADDR_W bits; no out-of-range condition exists.

Reset
REQ-023 While sys_rst_n=0: all registers 0, all busy bits 0, err 0, asynchronously.
REQ-024 While sys_rst_n=0: qa=qb=0, busy_a=busy_b=0, regardless of inputs and bypass.
REQ-025 Writes and bs_set asserted during reset are discarded; first update on the first rising edge after deassertion.
REQ-026 Reset mid-operation drops all pending busy bits; a later we1 to a formerly-busy register sets err.

Structure
REQ-027 Shared package/include holds default DATA_W/ADDR_W and the bypass priority encoding constants.
REQ-028 Scoreboard (busy vector, set/clear, err) is one sub-module d16_scoreboard; storage and bypass stay in the top.
REQ-029 Storage is a flat register array with no block RAM inference required.

Verification
REQ-030 Reset, then read all 16 addresses -> qa=qb=0x0000, busy_a=busy_b=0, err=0.
REQ-031 we0 addr_w0=3 data_w0=0x1234, addr_a=3 same cycle -> qa=0x1234; next cycle with we0=0 -> qa=0x1234 from storage.
REQ-032 we0 and we1 both to 5, data 0xAAAA/0x5555 -> qa=0x5555 that cycle and after.
REQ-033 ZERO_R0=1, we0 to 0 with 0xFFFF -> qa for address 0 stays 0x0000.
REQ-034 bs_set 7, next cycle addr_b=7 -> busy_b=1; we1 7 0xBEEF -> busy_b=0 and qb=0xBEEF same cycle; busy bit clear afterwards, err=0.
REQ-035 bs_set 7 twice with no we1 -> err=1 and held; sys_rst_n pulse low mid-sequence -> err=0, busy cleared, qa=0x0000.

Source files
------------

// File: rtl/d16_regfile_pkg.sv
// Shared defaults and read-bypass source encoding for the d16 register file.
package d16_regfile_pkg;

    localparam int D16_DATA_W = 16;
    localparam int D16_ADDR_W = 4;

    // Read source, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        BYP_ZERO  = 2'd3,
        BYP_W1    = 2'd2,
        BYP_W0    = 2'd1,
        BYP_STORE = 2'd0
    } byp_sel_e;

    function automatic byp_sel_e byp_select(input logic zero_hit,
                                            input logic w1_hit,
                                            input logic w0_hit);
        if (zero_hit)    return BYP_ZERO;
        else if (w1_hit) return BYP_W1;
        else if (w0_hit) return BYP_W0;
        else             return BYP_STORE;
    endfunction

endpackage

// File: rtl/d16_regfile_if.sv
// Bus bundle for the d16 register file: two read ports, two write ports, load scoreboard.
interface d16_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic              busy_a;
    logic              busy_b;
    logic              we0;
    logic [ADDR_W-1:0] addr_w0;
    logic [DATA_W-1:0] data_w0;
    logic              we1;
    logic [ADDR_W-1:0] addr_w1;
    logic [DATA_W-1:0] data_w1;
    logic              bs_set;
    logic [ADDR_W-1:0] bs_addr;
    logic              err;

    modport master (
        output addr_a, addr_b, we0, addr_w0, data_w0,
               we1, addr_w1, data_w1, bs_set, bs_addr,
        input  qa, qb, busy_a, busy_b, err
    );

    modport slave (
        input  addr_a, addr_b, we0, addr_w0, data_w0,
               we1, addr_w1, data_w1, bs_set, bs_addr,
        output qa, qb, busy_a, busy_b, err
    );
endinterface

// File: rtl/d16_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by load issue, cleared by load completion.
module d16_scoreboard #(
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_bs_set,
    input  logic [ADDR_W-1:0] i_bs_addr,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr_w1,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic              o_busy_a,
    output logic              o_busy_b,
    output logic              o_err
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] w_busy;
    logic             w_set_ok;
    logic             w_clr_ok;
    logic             w_err_set;
    logic             r_err;

    // With a hardwired zero register, traffic to address 0 never touches the scoreboard.
    assign w_set_ok = i_bs_set && !(ZERO_R0 && (i_bs_addr == '0));
    assign w_clr_ok = i_we1 && !(ZERO_R0 && (i_addr_w1 == '0));

    assign w_err_set = (w_set_ok && w_busy[i_bs_addr] &&
                        !(w_clr_ok && (i_addr_w1 == i_bs_addr))) ||
                       (w_clr_ok && !w_busy[i_addr_w1]);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic r_q;

            // A new load issue wins over a completing one to the same register.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n)
                    r_q <= 1'b0;
                else if (w_set_ok && (i_bs_addr == IDX))
                    r_q <= 1'b1;
                else if (w_clr_ok && (i_addr_w1 == IDX))
                    r_q <= 1'b0;
            end

            assign w_busy[gi] = r_q;
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_err <= 1'b0;
        else if (w_err_set)
            r_err <= 1'b1;
    end

    assign o_busy_a = sys_rst_n && w_busy[i_addr_a] && !(i_we1 && (i_addr_w1 == i_addr_a));
    assign o_busy_b = sys_rst_n && w_busy[i_addr_b] && !(i_we1 && (i_addr_w1 == i_addr_b));
    assign o_err    = r_err;

endmodule

// File: rtl/d16_regfile.sv
// Two-write, two-read register file with same-cycle write bypass and a load scoreboard.
module d16_regfile
    import d16_regfile_pkg::*;
#(
    parameter int DATA_W  = D16_DATA_W,
    parameter int ADDR_W  = D16_ADDR_W,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    d16_regfile_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] w_mem [DEPTH];
    byp_sel_e          w_sel_a;
    byp_sel_e          w_sel_b;
    logic [DATA_W-1:0] w_qa;
    logic [DATA_W-1:0] w_qb;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic [DATA_W-1:0] r_q;

            if (ZERO_R0 && (gi == 0)) begin : g_zero
                always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                    if (!sys_rst_n)
                        r_q <= '0;
                    else
                        r_q <= '0;
                end
            end else begin : g_store
                // Port 1 (load completion) takes precedence over port 0.
                always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                    if (!sys_rst_n)
                        r_q <= '0;
                    else if (bus.we1 && (bus.addr_w1 == IDX))
                        r_q <= bus.data_w1;
                    else if (bus.we0 && (bus.addr_w0 == IDX))
                        r_q <= bus.data_w0;
                end
            end

            assign w_mem[gi] = r_q;
        end
    endgenerate

    always_comb begin
        w_sel_a = byp_select(ZERO_R0 && (bus.addr_a == '0),
                             bus.we1 && (bus.addr_w1 == bus.addr_a),
                             bus.we0 && (bus.addr_w0 == bus.addr_a));
        w_sel_b = byp_select(ZERO_R0 && (bus.addr_b == '0),
                             bus.we1 && (bus.addr_w1 == bus.addr_b),
                             bus.we0 && (bus.addr_w0 == bus.addr_b));

        w_qa = w_mem[bus.addr_a];
        case (w_sel_a)
            BYP_ZERO: w_qa = '0;
            BYP_W1:   w_qa = bus.data_w1;
            BYP_W0:   w_qa = bus.data_w0;
            default:  w_qa = w_mem[bus.addr_a];
        endcase

        w_qb = w_mem[bus.addr_b];
        case (w_sel_b)
            BYP_ZERO: w_qb = '0;
            BYP_W1:   w_qb = bus.data_w1;
            BYP_W0:   w_qb = bus.data_w0;
            default:  w_qb = w_mem[bus.addr_b];
        endcase
    end

    // Reset must also mask the bypass path, which would otherwise forward live write data.
    assign bus.qa = sys_rst_n ? w_qa : '0;
    assign bus.qb = sys_rst_n ? w_qb : '0;

    d16_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_bs_set  (bus.bs_set),
        .i_bs_addr (bus.bs_addr),
        .i_we1     (bus.we1),
        .i_addr_w1 (bus.addr_w1),
        .i_addr_a  (bus.addr_a),
        .i_addr_b  (bus.addr_b),
        .o_busy_a  (bus.busy_a),
        .o_busy_b  (bus.busy_b),
        .o_err     (bus.err)
    );

endmodule

// File: tb/tb_d16_regfile.sv
// Directed bench for d16_regfile: default instance plus a ZERO_R0=1 instance.
module tb_d16_regfile;
    import d16_regfile_pkg::*;

    logic sys_clk;
    logic sys_rst_n;
    int   vectors;
    int   miscompares;

    d16_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();
    d16_regfile_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

    d16_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b0)) u_dut0 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus0)
    );

    d16_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1)) u_dut1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus1)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus0.addr_a = '0; bus0.addr_b = '0;
        bus0.we0 = 1'b0; bus0.addr_w0 = '0; bus0.data_w0 = '0;
        bus0.we1 = 1'b0; bus0.addr_w1 = '0; bus0.data_w1 = '0;
        bus0.bs_set = 1'b0; bus0.bs_addr = '0;
        bus1.addr_a = '0; bus1.addr_b = '0;
        bus1.we0 = 1'b0; bus1.addr_w0 = '0; bus1.data_w0 = '0;
        bus1.we1 = 1'b0; bus1.addr_w1 = '0; bus1.data_w1 = '0;
        bus1.bs_set = 1'b0; bus1.bs_addr = '0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge sys_clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst_n   = 1'b0;
        idle();

        // Activity during reset must be invisible and discarded.
        bus0.we0 = 1'b1; bus0.addr_w0 = 4'd3; bus0.data_w0 = 16'hDEAD;
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd2; bus0.data_w1 = 16'hBEEF;
        bus0.bs_set = 1'b1; bus0.bs_addr = 4'd2;
        bus0.addr_a = 4'd3; bus0.addr_b = 4'd2;
        settle();
        check("rst_qa_bypass", 32'(bus0.qa), 32'h0);
        check("rst_qb_bypass", 32'(bus0.qb), 32'h0);
        check("rst_busy_b", 32'(bus0.busy_b), 32'h0);
        check("rst_err", 32'(bus0.err), 32'h0);
        step();
        step();
        sys_rst_n = 1'b1;
        idle();

        for (int i = 0; i < 16; i++) begin
            bus0.addr_a = 4'(i);
            bus0.addr_b = 4'(15 - i);
            settle();
            $display("read a=%0d b=%0d qa=%h qb=%h", i, 15 - i, bus0.qa, bus0.qb);
            check("post_rst_qa", 32'(bus0.qa), 32'h0);
            check("post_rst_qb", 32'(bus0.qb), 32'h0);
            check("post_rst_busy_a", 32'(bus0.busy_a), 32'h0);
            check("post_rst_busy_b", 32'(bus0.busy_b), 32'h0);
            check("post_rst_err", 32'(bus0.err), 32'h0);
            step();
        end

        // we0 bypass then storage
        idle();
        bus0.we0 = 1'b1; bus0.addr_w0 = 4'd3; bus0.data_w0 = 16'h1234; bus0.addr_a = 4'd3;
        settle();
        check("w0_bypass_qa", 32'(bus0.qa), 32'h1234);
        step();
        bus0.we0 = 1'b0;
        settle();
        check("w0_store_qa", 32'(bus0.qa), 32'h1234);
        $display("we0 r3 <= 1234 qa=%h", bus0.qa);
        step();

        // Both ports to 5, preceded by a load issue so we1 is a legal completion
        idle();
        bus0.bs_set = 1'b1; bus0.bs_addr = 4'd5;
        step();
        idle();
        bus0.we0 = 1'b1; bus0.addr_w0 = 4'd5; bus0.data_w0 = 16'hAAAA;
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd5; bus0.data_w1 = 16'h5555;
        bus0.addr_a = 4'd5; bus0.addr_b = 4'd5;
        settle();
        check("dual_bypass_qa", 32'(bus0.qa), 32'h5555);
        check("dual_busy_masked", 32'(bus0.busy_b), 32'h0);
        step();
        idle();
        bus0.addr_a = 4'd5;
        settle();
        check("dual_store_qa", 32'(bus0.qa), 32'h5555);
        check("dual_busy_a", 32'(bus0.busy_a), 32'h0);
        check("dual_err", 32'(bus0.err), 32'h0);
        $display("dual write r5 qa=%h err=%b", bus0.qa, bus0.err);
        step();

        // Hardwired zero register on the ZERO_R0 instance
        idle();
        bus1.we0 = 1'b1; bus1.addr_w0 = 4'd0; bus1.data_w0 = 16'hFFFF; bus1.addr_a = 4'd0;
        bus1.bs_set = 1'b1; bus1.bs_addr = 4'd0;
        settle();
        check("zr0_bypass_qa", 32'(bus1.qa), 32'h0);
        step();
        idle();
        bus1.we0 = 1'b1; bus1.addr_w0 = 4'd1; bus1.data_w0 = 16'h00C3; bus1.addr_b = 4'd1;
        settle();
        check("zr0_store_qa", 32'(bus1.qa), 32'h0);
        check("zr0_busy_a", 32'(bus1.busy_a), 32'h0);
        check("zr0_r1_bypass_qb", 32'(bus1.qb), 32'h00C3);
        $display("zero_r0 qa=%h qb(r1)=%h", bus1.qa, bus1.qb);
        step();

        // Load issue / completion on 7
        idle();
        bus0.bs_set = 1'b1; bus0.bs_addr = 4'd7; bus0.addr_b = 4'd7;
        settle();
        check("bs7_busy_same_cycle", 32'(bus0.busy_b), 32'h0);
        step();
        idle();
        bus0.addr_b = 4'd7;
        settle();
        check("bs7_busy_b", 32'(bus0.busy_b), 32'h1);
        step();
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd7; bus0.data_w1 = 16'hBEEF;
        settle();
        check("ld7_busy_b_masked", 32'(bus0.busy_b), 32'h0);
        check("ld7_qb_bypass", 32'(bus0.qb), 32'hBEEF);
        step();
        bus0.we1 = 1'b0;
        settle();
        check("ld7_busy_b_after", 32'(bus0.busy_b), 32'h0);
        check("ld7_qb_store", 32'(bus0.qb), 32'hBEEF);
        check("ld7_err", 32'(bus0.err), 32'h0);
        $display("load r7 qb=%h busy=%b err=%b", bus0.qb, bus0.busy_b, bus0.err);
        step();

        // we0 to a busy register keeps the busy bit
        idle();
        bus0.bs_set = 1'b1; bus0.bs_addr = 4'd8;
        step();
        idle();
        bus0.we0 = 1'b1; bus0.addr_w0 = 4'd8; bus0.data_w0 = 16'h1111; bus0.addr_a = 4'd8;
        settle();
        check("w0busy_qa", 32'(bus0.qa), 32'h1111);
        check("w0busy_busy_a", 32'(bus0.busy_a), 32'h1);
        step();
        bus0.we0 = 1'b0;
        settle();
        check("w0busy_busy_kept", 32'(bus0.busy_a), 32'h1);
        step();
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd8; bus0.data_w1 = 16'h2222;
        step();
        bus0.we1 = 1'b0;
        settle();
        check("w0busy_cleared", 32'(bus0.busy_a), 32'h0);
        check("w0busy_qa_w1", 32'(bus0.qa), 32'h2222);
        step();

        // Simultaneous completion and re-issue on 9: busy stays set, no error
        idle();
        bus0.bs_set = 1'b1; bus0.bs_addr = 4'd9;
        step();
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd9; bus0.data_w1 = 16'h3333; bus0.addr_a = 4'd9;
        step();
        idle();
        bus0.addr_a = 4'd9;
        settle();
        check("reissue_busy_a", 32'(bus0.busy_a), 32'h1);
        check("reissue_qa", 32'(bus0.qa), 32'h3333);
        check("reissue_err", 32'(bus0.err), 32'h0);
        step();
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd9; bus0.data_w1 = 16'h3334;
        step();
        idle();

        // Double issue on 7 -> sticky error, then async reset mid-sequence
        bus0.bs_set = 1'b1; bus0.bs_addr = 4'd7;
        step();
        step();
        idle();
        bus0.addr_a = 4'd5; bus0.addr_b = 4'd7;
        settle();
        check("dbl_err", 32'(bus0.err), 32'h1);
        step();
        settle();
        check("dbl_err_held", 32'(bus0.err), 32'h1);
        check("dbl_busy_b", 32'(bus0.busy_b), 32'h1);
        check("dbl_qa_r5", 32'(bus0.qa), 32'h5555);
        #1 sys_rst_n = 1'b0;
        #1;
        check("arst_err", 32'(bus0.err), 32'h0);
        check("arst_qa", 32'(bus0.qa), 32'h0);
        check("arst_busy_b", 32'(bus0.busy_b), 32'h0);
        $display("async reset err=%b qa=%h busy_b=%b", bus0.err, bus0.qa, bus0.busy_b);
        step();
        sys_rst_n = 1'b1;
        settle();
        check("post_arst_qa_r5", 32'(bus0.qa), 32'h0);
        check("post_arst_busy_b", 32'(bus0.busy_b), 32'h0);
        check("post_arst_err", 32'(bus0.err), 32'h0);
        step();
        bus0.we1 = 1'b1; bus0.addr_w1 = 4'd7; bus0.data_w1 = 16'h7777;
        step();
        idle();
        settle();
        check("stale_ld_err", 32'(bus0.err), 32'h1);
        $display("stale load r7 err=%b", bus0.err);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
